// File: rtl/riscv_lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 encodings,
// FSM state enum, default bus timeout and small decode helpers.
package riscv_lsu_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Legal funct3 codes differ between loads and stores.
  function automatic logic lsu_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Size is carried in funct3[1:0] for both loads and stores.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    if (f3[1:0] == 2'b01) return lo[0];
    if (f3[1:0] == 2'b10) return (lo != 2'b00);
    return 1'b0;
  endfunction

  // Byte-lane mask for an access of the given size at byte offset lo.
  function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a bus word and sign- or
// zero-extends it according to funct3.
module load_extend
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select and extension.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    value    = 32'h0;
    case (addr_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  value = {24'h0, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  value = {16'h0, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: checks alignment/legality, runs one bus
// transaction per access with a timeout, and stalls the pipeline meanwhile.
module memory_access_unit
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  output logic [31:0] read_m,
  output logic        stall_m,
  output logic        misalign_m,
  output logic        bus_err_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] result_q, result_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        bus_err_q, bus_err_d;

  logic        access;
  logic        is_store;
  logic        op_ok;
  logic [31:0] store_word;
  logic [31:0] load_value;

  load_extend u_load_extend (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .value   (load_value)
  );

  // Decode of the incoming Memory-stage op; a simultaneous read is treated as a store.
  always_comb begin
    access     = mem_read_m | mem_write_m;
    is_store   = mem_write_m;
    op_ok      = lsu_legal(is_store, funct3_m) &&
                 !lsu_misaligned(funct3_m, alu_result_m[1:0]);
    store_word = write_data_m;
    case (funct3_m[1:0])
      2'b00:   store_word = {4{write_data_m[7:0]}};
      2'b01:   store_word = {2{write_data_m[15:0]}};
      default: store_word = write_data_m;
    endcase
  end

  // State and bus registers; reset drops the request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 8'h00;
      result_q   <= 32'h0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      result_q   <= result_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Next-state logic and Memory-stage outputs.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    result_d   = result_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    bus_err_d  = bus_err_q;
    stall_m    = 1'b0;
    misalign_m = 1'b0;
    read_m     = 32'h0;
    bus_err_m  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (op_ok) begin
            stall_m    = 1'b1;
            state_d    = ST_BUSY;
            wait_cnt_d = 8'h00;
            req_d      = 1'b1;
            we_d       = is_store;
            addr_d     = {alu_result_m[31:2], 2'b00};
            be_d       = lsu_byte_en(funct3_m, alu_result_m[1:0]);
            wdata_d    = store_word;
            funct3_d   = funct3_m;
            addr_lo_d  = alu_result_m[1:0];
            bus_err_d  = 1'b0;
          end else begin
            misalign_m = 1'b1;
          end
        end
      end

      ST_BUSY: begin
        stall_m = 1'b1;
        if (dmem_ack) begin
          // Ack wins even on the timeout cycle.
          result_d  = we_q ? 32'h0 : load_value;
          bus_err_d = 1'b0;
          req_d     = 1'b0;
          state_d   = ST_DONE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          result_d  = 32'h0;
          bus_err_d = 1'b1;
          req_d     = 1'b0;
          state_d   = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'h01;
        end
      end

      ST_DONE: begin
        read_m    = result_q;
        bus_err_m = bus_err_q;
        bus_err_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with hand-computed expectations.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m;
  logic [31:0] read_m;
  logic        stall_m, misalign_m, bus_err_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int total = 0;
  int bad   = 0;

  // Per-operation observations.
  int          o_stall;
  logic [31:0] o_read;
  logic        o_err;
  logic        o_misal;
  logic        o_req_seen;
  logic        o_we;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wdata;
  logic        o_done;

  memory_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .funct3_m     (funct3_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .read_m       (read_m),
    .stall_m      (stall_m),
    .misalign_m   (misalign_m),
    .bus_err_m    (bus_err_m),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one Memory-stage op. Inputs are applied 1 time unit after a rising
  // edge; outputs are sampled on the falling edge. ack is raised on BUSY
  // cycle number 'waits' (counting from 0); waits < 0 means never.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rdata);
    int busy_idx;
    mem_read_m   = rd;
    mem_write_m  = wr;
    funct3_m     = f3;
    alu_result_m = addr;
    write_data_m = wd;
    o_stall = 0; o_read = 32'hx; o_err = 1'bx; o_misal = 1'b0;
    o_req_seen = 1'b0; o_we = 1'b0; o_addr = 32'h0; o_be = 4'h0; o_wdata = 32'h0;
    o_done = 1'b0;
    busy_idx = 0;
    for (int c = 0; c < 64 && !o_done; c++) begin
      if (dmem_req) begin
        dmem_ack   = (busy_idx == waits);
        dmem_rdata = rdata;
        busy_idx++;
      end else begin
        dmem_ack = 1'b0;
      end
      @(negedge clk);
      if (dmem_req && !o_req_seen) begin
        o_we = dmem_we; o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata;
      end
      o_req_seen = o_req_seen | dmem_req;
      o_misal    = o_misal | misalign_m;
      if (stall_m) begin
        o_stall++;
      end else begin
        o_done = 1'b1;
        o_read = read_m;
        o_err  = bus_err_m;
      end
      @(posedge clk); #1;
    end
    dmem_ack    = 1'b0;
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    check("op_completes", {31'h0, o_done}, 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    mem_read_m = 1'b0; mem_write_m = 1'b0; funct3_m = 3'b000;
    alu_result_m = 32'h0; write_data_m = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #12;
    check("rst_req",    {31'h0, dmem_req}, 32'h0);
    check("rst_we",     {31'h0, dmem_we}, 32'h0);
    check("rst_addr",   dmem_addr, 32'h0);
    check("rst_be",     {28'h0, dmem_be}, 32'h0);
    check("rst_wdata",  dmem_wdata, 32'h0);
    check("rst_stall",  {31'h0, stall_m}, 32'h0);
    check("rst_misal",  {31'h0, misalign_m}, 32'h0);
    check("rst_buserr", {31'h0, bus_err_m}, 32'h0);
    check("rst_read",   read_m, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // lw 0x100, ack on first BUSY cycle
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    check("lw_stall",  o_stall, 2);
    check("lw_read",   o_read, 32'hDEAD_BEEF);
    check("lw_addr",   o_addr, 32'h0000_0100);
    check("lw_be",     {28'h0, o_be}, 32'hF);
    check("lw_we",     {31'h0, o_we}, 32'h0);
    check("lw_err",    {31'h0, o_err}, 32'h0);
    check("idle_read", read_m, 32'h0);

    // lb / lbu 0x103
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_FFFF);
    check("lb_read", o_read, 32'hFFFF_FF80);
    check("lb_be",   {28'h0, o_be}, 32'h8);
    check("lb_addr", o_addr, 32'h0000_0100);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h80FF_FFFF);
    check("lbu_read",  o_read, 32'h0000_0080);
    check("lbu_stall", o_stall, 3);

    // lh / lhu 0x102
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h8001_1234);
    check("lh_read",  o_read, 32'hFFFF_8001);
    check("lh_be",    {28'h0, o_be}, 32'hC);
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 0, 32'h8001_9234);
    check("lhu_read", o_read, 32'h0000_9234);

    // sh 0x202, ack after 3 wait cycles
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'hFFFF_FFFF);
    check("sh_be",    {28'h0, o_be}, 32'hC);
    check("sh_wdata", o_wdata, 32'hABCD_ABCD);
    check("sh_we",    {31'h0, o_we}, 32'h1);
    check("sh_addr",  o_addr, 32'h0000_0200);
    check("sh_stall", o_stall, 5);
    check("sh_read",  o_read, 32'h0);

    // sb 0x001
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 0, 32'h0);
    check("sb_be",    {28'h0, o_be}, 32'h2);
    check("sb_wdata", o_wdata, 32'hA5A5_A5A5);

    // misaligned lw 0x101
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'h0);
    check("mis_lw_pulse", {31'h0, o_misal}, 32'h1);
    check("mis_lw_req",   {31'h0, o_req_seen}, 32'h0);
    check("mis_lw_stall", o_stall, 0);
    check("mis_lw_read",  o_read, 32'h0);
    @(negedge clk);
    check("mis_lw_once",  {31'h0, misalign_m}, 32'h0);
    @(posedge clk); #1;

    // illegal load funct3 011, illegal store funct3 100
    run_op(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
    check("ill_ld_pulse", {31'h0, o_misal}, 32'h1);
    check("ill_ld_req",   {31'h0, o_req_seen}, 32'h0);
    check("ill_ld_stall", o_stall, 0);
    run_op(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 32'h0);
    check("ill_st_pulse", {31'h0, o_misal}, 32'h1);
    check("ill_st_req",   {31'h0, o_req_seen}, 32'h0);

    // timeout with no ack
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, -1, 32'h1234_5678);
    check("to_err",   {31'h0, o_err}, 32'h1);
    check("to_read",  o_read, 32'h0);
    check("to_stall", o_stall, 17);
    @(negedge clk);
    check("to_err_pulse", {31'h0, bus_err_m}, 32'h0);
    @(posedge clk); #1;

    // ack on the timeout cycle counts as success
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 15, 32'h1234_5678);
    check("to_edge_err",  {31'h0, o_err}, 32'h0);
    check("to_edge_read", o_read, 32'h1234_5678);
    check("to_edge_stall", o_stall, 17);

    // ack outside BUSY is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("stray_ack_stall", {31'h0, stall_m}, 32'h0);
    @(posedge clk); #1;
    check("stray_ack_req",  {31'h0, dmem_req}, 32'h0);
    check("stray_ack_read", read_m, 32'h0);
    dmem_ack = 1'b0;

    // read+write together behaves as sw
    run_op(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344, 0, 32'hFFFF_FFFF);
    check("rw_we",    {31'h0, o_we}, 32'h1);
    check("rw_be",    {28'h0, o_be}, 32'hF);
    check("rw_wdata", o_wdata, 32'h1122_3344);
    check("rw_read",  o_read, 32'h0);

    // reset asserted mid-BUSY
    mem_read_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h0000_0500;
    @(posedge clk); #1;
    check("rstb_req_before", {31'h0, dmem_req}, 32'h1);
    mem_read_m = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstb_req_now", {31'h0, dmem_req}, 32'h0);
    check("rstb_stall",   {31'h0, stall_m}, 32'h0);
    check("rstb_addr",    dmem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstb_idle_stall", {31'h0, stall_m}, 32'h0);
    check("rstb_idle_read",  read_m, 32'h0);
    @(posedge clk); #1;

    // normal operation after reset
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 0, 32'h0BAD_F00D);
    check("post_rst_read",  o_read, 32'h0BAD_F00D);
    check("post_rst_stall", o_stall, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
